b_register_bank: RTL and testbench

- Parametrised successor of the single-register B block: a bank of DEPTH registers, each WIDTH bits, loaded from WBUS or updated in place by increment, decrement or shift-left.
- Two independent read ports feed the ALU operand inputs.
- Zero and carry/borrow flags record the result of the most recent write.
- Sits between WBUS and the ALU; the controller drives select, mode and the active-low load strobe.

---
 rtl/sap_pkg.sv | 13 +
 rtl/b_register_bank_if.sv | 26 ++
 rtl/b_register_step.sv | 41 ++++
 rtl/b_register_bank.sv | 76 +++++++
 tb/tb_b_register_bank.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared constants for the B register bank datapath
package sap_pkg;

    localparam logic [1:0] MODE_LOAD = 2'b00;
    localparam logic [1:0] MODE_INC  = 2'b01;
    localparam logic [1:0] MODE_DEC  = 2'b10;
    localparam logic [1:0] MODE_SHL  = 2'b11;

    // Reference width of the zero-state constant; users cast it to their own WIDTH
    localparam int SAP_WIDTH = 8;
    localparam logic [SAP_WIDTH-1:0] ZERO_STATE = '0;

endpackage

// File: rtl/b_register_bank_if.sv
// rtl/b_register_bank_if.sv - controller/ALU side bundle of the B register bank
interface b_register_bank_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic             nLb;
    logic [1:0]       MODE;
    logic [SEL_W-1:0] WSEL;
    logic [WIDTH-1:0] WBUS;
    logic [SEL_W-1:0] RSELA;
    logic [SEL_W-1:0] RSELB;
    logic [WIDTH-1:0] ALUA;
    logic [WIDTH-1:0] ALUB;
    logic             ZF;
    logic             CF;

    modport master (
        output nLb, MODE, WSEL, WBUS, RSELA, RSELB,
        input  ALUA, ALUB, ZF, CF
    );

    modport slave (
        input  nLb, MODE, WSEL, WBUS, RSELA, RSELB,
        output ALUA, ALUB, ZF, CF
    );
endinterface

// File: rtl/b_register_step.sv
// rtl/b_register_step.sv - combinational next value and carry for one register write
module b_register_step
    import sap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] wbus,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] new_val,
    output logic             carry
);

    // Select the operation; carry reports wrap, borrow or the bit shifted out
    always_comb begin
        new_val = old_val;
        carry   = 1'b0;
        case (mode)
            MODE_LOAD: begin
                new_val = wbus;
                carry   = 1'b0;
            end
            MODE_INC: begin
                {carry, new_val} = {1'b0, old_val} + {{WIDTH{1'b0}}, 1'b1};
            end
            MODE_DEC: begin
                new_val = old_val - {{(WIDTH-1){1'b0}}, 1'b1};
                carry   = (old_val == '0);
            end
            MODE_SHL: begin
                new_val = {old_val[WIDTH-2:0], 1'b0};
                carry   = old_val[WIDTH-1];
            end
            default: begin
                new_val = old_val;
                carry   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/b_register_bank.sv
// rtl/b_register_bank.sv - DEPTH x WIDTH register bank with two read ports and result flags
module b_register_bank
    import sap_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               CLR,
    b_register_bank_if.slave   bus
);

    localparam logic [WIDTH-1:0] ZERO_W = WIDTH'(ZERO_STATE);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] sel_old;
    logic [WIDTH-1:0] step_new;
    logic             step_carry;
    logic             wsel_hit;
    logic             zf_q;
    logic             cf_q;

    // Fetch the register addressed by WSEL; a select past the bank never hits
    always_comb begin
        sel_old  = ZERO_W;
        wsel_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.WSEL == SEL_W'(i)) begin
                sel_old  = regs[i];
                wsel_hit = 1'b1;
            end
        end
    end

    b_register_step #(.WIDTH(WIDTH)) u_step (
        .old_val (sel_old),
        .wbus    (bus.WBUS),
        .mode    (bus.MODE),
        .new_val (step_new),
        .carry   (step_carry)
    );

    // Write one register per edge and capture its flags; out-of-range selects hold everything
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= ZERO_W;
            end
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else if (!bus.nLb && wsel_hit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (bus.WSEL == SEL_W'(i)) begin
                    regs[i] <= step_new;
                end
            end
            zf_q <= (step_new == ZERO_W);
            cf_q <= step_carry;
        end
    end

    // Read ports straight off the array, no bypass; unmatched selects read zero
    always_comb begin
        bus.ALUA = ZERO_W;
        bus.ALUB = ZERO_W;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.RSELA == SEL_W'(i)) bus.ALUA = regs[i];
            if (bus.RSELB == SEL_W'(i)) bus.ALUB = regs[i];
        end
    end

    assign bus.ZF = zf_q;
    assign bus.CF = cf_q;

endmodule

// File: tb/tb_b_register_bank.sv
// tb/tb_b_register_bank.sv - randomized and directed check of b_register_bank against an array model
module tb_b_register_bank;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int SEL_W = $clog2(DEPTH);

    logic CLK;
    logic CLR;

    b_register_bank_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

    b_register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    int model [DEPTH];
    int m_zf;
    int m_cf;
    int n_vec;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rd(input int sel);
        return (sel < DEPTH) ? model[sel] : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 0;
        m_zf = 0;
        m_cf = 0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.RSELA = SEL_W'(i);
            bus.RSELB = SEL_W'(3 - i);
            #1;
            check({tag, "_alua"}, 32'(bus.ALUA), rd(i));
            check({tag, "_alub"}, 32'(bus.ALUB), rd(3 - i));
        end
        check({tag, "_zf"}, 32'(bus.ZF), m_zf);
        check({tag, "_cf"}, 32'(bus.CF), m_cf);
    endtask

    task automatic expect_reg(input string tag, input int sel, input int val, input int zf, input int cf);
        bus.RSELA = SEL_W'(sel);
        #1;
        check({tag, "_val"}, 32'(bus.ALUA), val);
        check({tag, "_zf"}, 32'(bus.ZF), zf);
        check({tag, "_cf"}, 32'(bus.CF), cf);
    endtask

    // One clock of stimulus; the model is evaluated with plain integer arithmetic
    task automatic step(input logic nlb, input logic [1:0] mode, input int wsel, input logic [7:0] wbus);
        int old_v;
        int tmp;
        int nv;
        int ncf;
        @(negedge CLK);
        bus.nLb   = nlb;
        bus.MODE  = mode;
        bus.WSEL  = SEL_W'(wsel);
        bus.WBUS  = wbus;
        bus.RSELA = SEL_W'(wsel);
        #1;
        check("pre_edge_old", 32'(bus.ALUA), rd(wsel));
        nv  = 0;
        ncf = 0;
        if (!nlb && wsel < DEPTH) begin
            old_v = model[wsel];
            case (mode)
                2'd0: begin nv = int'(wbus); ncf = 0; end
                2'd1: begin tmp = old_v + 1; ncf = (tmp > 255) ? 1 : 0; nv = tmp % 256; end
                2'd2: begin tmp = old_v - 1; ncf = (tmp < 0) ? 1 : 0; nv = (tmp + 256) % 256; end
                default: begin tmp = old_v * 2; ncf = (tmp >= 256) ? 1 : 0; nv = tmp % 256; end
            endcase
        end
        @(posedge CLK);
        #1;
        bus.nLb = 1'b1;
        if (!nlb && wsel < DEPTH) begin
            model[wsel] = nv;
            m_zf = (nv == 0) ? 1 : 0;
            m_cf = ncf;
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        model_clear();
        CLR       = 1'b1;
        bus.nLb   = 1'b1;
        bus.MODE  = 2'b00;
        bus.WSEL  = '0;
        bus.WBUS  = '0;
        bus.RSELA = '0;
        bus.RSELB = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset_state");
        @(negedge CLK);
        CLR = 1'b0;

        // Asynchronous reset in the middle of a cycle, with flags set beforehand
        step(1'b0, 2'b00, 1, 8'hA5);
        step(1'b0, 2'b00, 0, 8'hFF);
        step(1'b0, 2'b01, 0, 8'h00);
        expect_reg("pre_reset", 1, 8'hA5, 1, 1);
        @(negedge CLK);
        #3;
        CLR = 1'b1;
        #1;
        model_clear();
        expect_reg("async_reset", 1, 8'h00, 0, 0);
        bus.nLb  = 1'b0;
        bus.MODE = 2'b00;
        bus.WSEL = SEL_W'(1);
        bus.WBUS = 8'hFF;
        @(posedge CLK);
        #1;
        expect_reg("clr_blocks_write", 1, 8'h00, 0, 0);
        @(negedge CLK);
        CLR     = 1'b0;
        bus.nLb = 1'b1;

        // Load and hold
        step(1'b0, 2'b00, 2, 8'h3C);
        bus.RSELA = SEL_W'(2);
        bus.RSELB = SEL_W'(0);
        #1;
        check("load_alua", 32'(bus.ALUA), 32'h3C);
        check("load_alub", 32'(bus.ALUB), 32'h00);
        check_all("load");
        step(1'b1, 2'b01, 2, 8'h00);
        check_all("hold");

        // Increment wrap
        step(1'b0, 2'b00, 0, 8'hFF);
        step(1'b0, 2'b01, 0, 8'h00);
        expect_reg("inc_wrap", 0, 8'h00, 1, 1);
        step(1'b0, 2'b01, 0, 8'h00);
        expect_reg("inc_again", 0, 8'h01, 0, 0);

        // Decrement borrow (reg2 stands in for the last register of the bank)
        step(1'b0, 2'b00, 2, 8'h00);
        step(1'b0, 2'b10, 2, 8'h00);
        expect_reg("dec_borrow", 2, 8'hFF, 0, 1);
        step(1'b0, 2'b00, 2, 8'h01);
        step(1'b0, 2'b10, 2, 8'h00);
        expect_reg("dec_to_zero", 2, 8'h00, 1, 0);

        // Shift-left
        step(1'b0, 2'b00, 1, 8'h81);
        step(1'b0, 2'b11, 1, 8'h00);
        expect_reg("shl_out", 1, 8'h02, 0, 1);
        step(1'b0, 2'b11, 1, 8'h00);
        expect_reg("shl_again", 1, 8'h04, 0, 0);

        // Out-of-range write select holds registers and flags
        step(1'b0, 2'b00, 0, 8'hFF);
        step(1'b0, 2'b01, 0, 8'h00);
        step(1'b0, 2'b00, 3, 8'h55);
        expect_reg("oor_write", 0, 8'h00, 1, 1);
        expect_reg("oor_read", 3, 8'h00, 1, 1);
        check_all("oor");

        // Randomized traffic including holds and out-of-range selects
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 8'($urandom));
            if (k % 10 == 9) check_all("random");
        end
        check_all("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
